// File: rtl/ed_pkg.sv
// Shared types and constants for the energy-detection configuration sequencer.
// Status layout: {state[2:0], 11'b0, err_timeout, err_ws, dropped_cnt[15:0]}.
package ed_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_RUN   = 3'd2,
      ST_DRAIN = 3'd3,
      ST_FLUSH = 3'd4
   } ed_state_t;

   localparam logic [7:0] DEF_TH_ADDR   = 8'd1;
   localparam logic [7:0] DEF_WS_ADDR   = 8'd3;
   localparam logic [7:0] DEF_CTRL_ADDR = 8'd5;

   localparam int COMMIT_BIT = 0;
   localparam int ENABLE_BIT = 1;

   localparam int STATUS_STATE_LSB       = 29;
   localparam int STATUS_ERR_TIMEOUT_BIT = 17;
   localparam int STATUS_ERR_WS_BIT      = 16;
   localparam int STATUS_DROP_LSB        = 0;

endpackage

// File: rtl/ed_settings_decode.sv
// Settings-bus decoder: holds the pending threshold/window registers and the
// enable/commit requests, plus same-cycle views of the requests for the FSM.
module ed_settings_decode
   import ed_pkg::*;
#(
   parameter logic [7:0]  TH_ADDR   = DEF_TH_ADDR,
   parameter logic [7:0]  WS_ADDR   = DEF_WS_ADDR,
   parameter logic [7:0]  CTRL_ADDR = DEF_CTRL_ADDR,
   parameter logic [31:0] TH_RESET  = 32'hFFFF_FFFF,
   parameter logic [9:0]  WS_RESET  = 10'd64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic        load_ack,
   output logic [31:0] pending_th,
   output logic [9:0]  pending_ws,
   output logic        en_req,
   output logic        commit_req,
   output logic        ctrl_wr,
   output logic        en_req_eff,
   output logic        commit_eff
);

   logic th_wr;
   logic ws_wr;

   // The FSM reacts to a CTRL write in the same cycle it appears on the bus.
   always_comb begin
      th_wr      = set_stb && (set_addr == TH_ADDR);
      ws_wr      = set_stb && (set_addr == WS_ADDR);
      ctrl_wr    = set_stb && (set_addr == CTRL_ADDR);
      en_req_eff = ctrl_wr ? set_data[ENABLE_BIT] : en_req;
      commit_eff = commit_req || (ctrl_wr && set_data[COMMIT_BIT]);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pending_th <= TH_RESET;
         pending_ws <= WS_RESET;
         en_req     <= 1'b0;
         commit_req <= 1'b0;
      end else begin
         if (th_wr)
            pending_th <= set_data;
         if (ws_wr)
            pending_ws <= set_data[9:0];
         if (ctrl_wr)
            en_req <= set_data[ENABLE_BIT];
         // LOAD absorbs any commit that arrived while it was already on its way.
         if (load_ack)
            commit_req <= 1'b0;
         else if (ctrl_wr && set_data[COMMIT_BIT])
            commit_req <= 1'b1;
      end
   end

endmodule

// File: rtl/ed_config_sequencer.sv
// Configuration/flush sequencer: gates samples into the energy-detection datapath
// and swaps threshold/window only after drain and flush.
module ed_config_sequencer
   import ed_pkg::*;
#(
   parameter logic [7:0]  TH_ADDR       = DEF_TH_ADDR,
   parameter logic [7:0]  WS_ADDR       = DEF_WS_ADDR,
   parameter logic [7:0]  CTRL_ADDR     = DEF_CTRL_ADDR,
   parameter logic [31:0] TH_RESET      = 32'hFFFF_FFFF,
   parameter logic [9:0]  WS_RESET      = 10'd64,
   parameter int          FLUSH_CYCLES  = 4,
   parameter int          DRAIN_TIMEOUT = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic        dv_in,
   input  logic        dp_idle,
   output logic        dv_gated,
   output logic        dp_enable,
   output logic        dp_sclr,
   output logic [31:0] th_value,
   output logic [9:0]  window_size,
   output logic        cfg_done,
   output logic [31:0] status
);

   localparam int TMAX = (DRAIN_TIMEOUT > FLUSH_CYCLES) ? DRAIN_TIMEOUT : FLUSH_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   ed_state_t      state;
   logic [TW-1:0]  timer;
   logic [15:0]    dropped_cnt;
   logic           err_timeout;
   logic           err_ws;
   logic [31:0]    pending_th;
   logic [9:0]     pending_ws;
   logic           en_req;
   logic           commit_req;
   logic           ctrl_wr;
   logic           en_req_eff;
   logic           commit_eff;
   logic           load_ack;

   assign load_ack = (state == ST_LOAD);
   assign dv_gated = dv_in & dp_enable;

   ed_settings_decode #(
      .TH_ADDR   (TH_ADDR),
      .WS_ADDR   (WS_ADDR),
      .CTRL_ADDR (CTRL_ADDR),
      .TH_RESET  (TH_RESET),
      .WS_RESET  (WS_RESET)
   ) u_decode (
      .clock      (clock),
      .reset      (reset),
      .set_stb    (set_stb),
      .set_addr   (set_addr),
      .set_data   (set_data),
      .load_ack   (load_ack),
      .pending_th (pending_th),
      .pending_ws (pending_ws),
      .en_req     (en_req),
      .commit_req (commit_req),
      .ctrl_wr    (ctrl_wr),
      .en_req_eff (en_req_eff),
      .commit_eff (commit_eff)
   );

   // Outputs are registered alongside the state so they change on the transition edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         dp_enable   <= 1'b0;
         dp_sclr     <= 1'b1;
         cfg_done    <= 1'b0;
         timer       <= '0;
         th_value    <= TH_RESET;
         window_size <= WS_RESET;
         err_timeout <= 1'b0;
         err_ws      <= 1'b0;
         dropped_cnt <= '0;
      end else begin
         cfg_done <= 1'b0;
         if (ctrl_wr) begin
            err_timeout <= 1'b0;
            err_ws      <= 1'b0;
            dropped_cnt <= '0;
         end else if (dv_in && !dp_enable && (state != ST_IDLE) && (dropped_cnt != 16'hFFFF)) begin
            dropped_cnt <= dropped_cnt + 16'd1;
         end

         case (state)
            ST_IDLE: begin
               if (en_req_eff)
                  state <= ST_LOAD;
            end
            ST_LOAD: begin
               th_value <= pending_th;
               if (pending_ws == 10'd0)
                  err_ws <= 1'b1;
               else
                  window_size <= pending_ws;
               cfg_done <= 1'b1;
               if (en_req_eff) begin
                  state     <= ST_RUN;
                  dp_enable <= 1'b1;
                  dp_sclr   <= 1'b0;
               end else begin
                  state   <= ST_IDLE;
                  dp_sclr <= 1'b1;
               end
            end
            ST_RUN: begin
               if (!en_req_eff || commit_eff) begin
                  state     <= ST_DRAIN;
                  dp_enable <= 1'b0;
                  timer     <= '0;
               end
            end
            ST_DRAIN: begin
               if (dp_idle || (timer == TW'(DRAIN_TIMEOUT - 1))) begin
                  if (!dp_idle)
                     err_timeout <= 1'b1;
                  timer   <= '0;
                  dp_sclr <= 1'b1;
                  state   <= en_req_eff ? ST_FLUSH : ST_IDLE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            ST_FLUSH: begin
               if (timer == TW'(FLUSH_CYCLES - 1)) begin
                  timer   <= '0;
                  dp_sclr <= 1'b0;
                  state   <= ST_LOAD;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               dp_enable <= 1'b0;
               dp_sclr   <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      status = '0;
      status[STATUS_STATE_LSB +: 3]     = state;
      status[STATUS_ERR_TIMEOUT_BIT]    = err_timeout;
      status[STATUS_ERR_WS_BIT]         = err_ws;
      status[STATUS_DROP_LSB +: 16]     = dropped_cnt;
   end

endmodule

// File: tb/tb_ed_config_sequencer.sv
// Randomized bench for ed_config_sequencer; expectations come from a
// transaction-level model of pending/active settings and gap lengths.
module tb_ed_config_sequencer;

   localparam logic [7:0]  TH_A   = 8'd1;
   localparam logic [7:0]  WS_A   = 8'd3;
   localparam logic [7:0]  CTRL_A = 8'd5;
   localparam int          FLUSH  = 4;
   localparam int          DTO    = 4096;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = 8'd0;
   logic [31:0] set_data = 32'd0;
   logic        dv_in = 1'b0;
   logic        dp_idle = 1'b1;
   logic        dv_gated;
   logic        dp_enable;
   logic        dp_sclr;
   logic [31:0] th_value;
   logic [9:0]  window_size;
   logic        cfg_done;
   logic [31:0] status;

   int errorCount = 0;
   int checkCount = 0;

   logic [31:0] pendTh, expTh;
   logic [9:0]  pendWs, expWs;

   ed_config_sequencer #(
      .TH_ADDR(TH_A), .WS_ADDR(WS_A), .CTRL_ADDR(CTRL_A),
      .TH_RESET(32'hFFFF_FFFF), .WS_RESET(10'd64),
      .FLUSH_CYCLES(FLUSH), .DRAIN_TIMEOUT(DTO)
   ) dut (
      .clock(clock), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
      .set_data(set_data), .dv_in(dv_in), .dp_idle(dp_idle), .dv_gated(dv_gated),
      .dp_enable(dp_enable), .dp_sclr(dp_sclr), .th_value(th_value),
      .window_size(window_size), .cfg_done(cfg_done), .status(status)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clock);
      #1;
   endtask

   task automatic modelReset();
      pendTh = 32'hFFFF_FFFF;
      pendWs = 10'd64;
      expTh  = 32'hFFFF_FFFF;
      expWs  = 10'd64;
   endtask

   // A LOAD copies pending to active, keeping the old window when pending is zero.
   task automatic modelLoad();
      expTh = pendTh;
      if (pendWs != 10'd0)
         expWs = pendWs;
   endtask

   task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data);
      set_stb  = 1'b1;
      set_addr = addr;
      set_data = data;
      if (addr == TH_A) pendTh = data;
      if (addr == WS_A) pendWs = data[9:0];
      stepClock();
      set_stb = 1'b0;
   endtask

   task automatic enableFromIdle(input string tag);
      applyStimulus(CTRL_A, 32'h2);
      checkOutput({tag, "_load_en"}, 32'(dp_enable), 32'd0);
      checkOutput({tag, "_load_sclr"}, 32'(dp_sclr), 32'd1);
      stepClock();
      modelLoad();
      checkOutput({tag, "_run_en"}, 32'(dp_enable), 32'd1);
      checkOutput({tag, "_run_sclr"}, 32'(dp_sclr), 32'd0);
      checkOutput({tag, "_done"}, 32'(cfg_done), 32'd1);
      checkOutput({tag, "_th"}, th_value, expTh);
      checkOutput({tag, "_ws"}, 32'(window_size), 32'(expWs));
      stepClock();
      checkOutput({tag, "_done_clr"}, 32'(cfg_done), 32'd0);
   endtask

   // Commit from RUN; dp_idle stays low for idleDelay gated cycles.
   task automatic commitAndMeasure(input string tag, input logic [31:0] newTh,
                                   input logic [9:0] newWs, input int idleDelay);
      int expDrain, expLow, lowCycles, sclrCycles, doneSeen, gateErr, expDrops, guard;
      logic expTimeout;
      logic earlyChange;
      expDrain   = (idleDelay + 1 <= DTO) ? idleDelay + 1 : DTO;
      expTimeout = (idleDelay >= DTO);
      expLow     = expDrain + FLUSH + 1;
      lowCycles = 0; sclrCycles = 0; doneSeen = 0; gateErr = 0; expDrops = 0; guard = 0;
      earlyChange = 1'b0;
      applyStimulus(TH_A, newTh);
      applyStimulus(WS_A, {22'd0, newWs});
      dp_idle = 1'b0;
      dv_in   = 1'b0;
      applyStimulus(CTRL_A, 32'h3);
      while (dp_enable == 1'b0 && guard < expLow + 50) begin
         dp_idle = (lowCycles >= idleDelay);
         dv_in   = 1'($urandom_range(0, 1));
         #1;
         if (dv_gated !== 1'b0) gateErr++;
         if (dv_in) expDrops++;
         if (dp_sclr) sclrCycles++;
         if (cfg_done) doneSeen++;
         if (th_value !== expTh || window_size !== expWs) earlyChange = 1'b1;
         lowCycles++;
         guard++;
         stepClock();
      end
      dv_in   = 1'b0;
      dp_idle = 1'b1;
      modelLoad();
      checkOutput({tag, "_low_cycles"}, 32'(lowCycles), 32'(expLow));
      checkOutput({tag, "_sclr_cycles"}, 32'(sclrCycles), 32'(FLUSH));
      checkOutput({tag, "_gated_leak"}, 32'(gateErr), 32'd0);
      checkOutput({tag, "_early_done"}, 32'(doneSeen), 32'd0);
      checkOutput({tag, "_early_cfg"}, 32'(earlyChange), 32'd0);
      checkOutput({tag, "_done"}, 32'(cfg_done), 32'd1);
      checkOutput({tag, "_sclr_run"}, 32'(dp_sclr), 32'd0);
      checkOutput({tag, "_th"}, th_value, expTh);
      checkOutput({tag, "_ws"}, 32'(window_size), 32'(expWs));
      checkOutput({tag, "_dropped"}, 32'(status[15:0]), 32'(expDrops));
      checkOutput({tag, "_err_to"}, 32'(status[17]), 32'(expTimeout));
      checkOutput({tag, "_err_ws"}, 32'(status[16]), 32'(newWs == 10'd0));
      dv_in = 1'b1;
      #1;
      checkOutput({tag, "_gated_pass"}, 32'(dv_gated), 32'd1);
      dv_in = 1'b0;
      stepClock();
      checkOutput({tag, "_done_clr"}, 32'(cfg_done), 32'd0);
   endtask

   initial begin
      int guard;
      logic [31:0] rTh;
      modelReset();
      #12;
      checkOutput("rst_en", 32'(dp_enable), 32'd0);
      checkOutput("rst_sclr", 32'(dp_sclr), 32'd1);
      checkOutput("rst_done", 32'(cfg_done), 32'd0);
      checkOutput("rst_th", th_value, 32'hFFFF_FFFF);
      checkOutput("rst_ws", 32'(window_size), 32'd64);
      checkOutput("rst_status_low", 32'(status[17:0]), 32'd0);
      reset = 1'b1;
      stepClock();

      dv_in = 1'b1;
      repeat (3) stepClock();
      checkOutput("idle_no_drop", 32'(status[15:0]), 32'd0);
      checkOutput("idle_gated", 32'(dv_gated), 32'd0);
      dv_in = 1'b0;

      enableFromIdle("en0");
      commitAndMeasure("c1000", 32'd1000, 10'd128, 0);
      commitAndMeasure("drain20", $urandom, 10'($urandom_range(1, 1023)), 20);
      for (int i = 0; i < 5; i++)
         commitAndMeasure($sformatf("rnd%0d", i), $urandom, 10'($urandom_range(1, 1023)),
                          $urandom_range(0, 25));
      commitAndMeasure("timeout", $urandom, 10'($urandom_range(1, 1023)), 5000);
      commitAndMeasure("ws0", $urandom, 10'd0, 2);
      applyStimulus(CTRL_A, 32'h2);
      checkOutput("ws0_err_clr", 32'(status[16]), 32'd0);
      checkOutput("ws0_en_kept", 32'(dp_enable), 32'd1);

      // Disable together with commit: drains straight to IDLE without loading.
      applyStimulus(WS_A, 32'd300);
      rTh = $urandom;
      applyStimulus(TH_A, rTh);
      applyStimulus(CTRL_A, 32'h1);
      guard = 0;
      repeat (4) begin
         stepClock();
         if (cfg_done) guard++;
      end
      checkOutput("dis_no_load", 32'(guard), 32'd0);
      checkOutput("dis_th_kept", th_value, expTh);
      checkOutput("dis_en", 32'(dp_enable), 32'd0);
      checkOutput("dis_sclr", 32'(dp_sclr), 32'd1);
      enableFromIdle("reen");

      // Disable arriving mid-FLUSH: LOAD still happens, then falls back to IDLE.
      applyStimulus(TH_A, $urandom);
      applyStimulus(CTRL_A, 32'h3);
      stepClock();
      applyStimulus(CTRL_A, 32'h0);
      guard = 0;
      while (!cfg_done && guard < 20) begin
         stepClock();
         guard++;
      end
      modelLoad();
      checkOutput("mid_done_seen", 32'(cfg_done), 32'd1);
      checkOutput("mid_sclr", 32'(dp_sclr), 32'd1);
      checkOutput("mid_en", 32'(dp_enable), 32'd0);
      checkOutput("mid_th", th_value, expTh);
      repeat (3) stepClock();
      checkOutput("mid_stay_idle", 32'(dp_enable), 32'd0);
      enableFromIdle("en2");

      // Asynchronous reset in the middle of FLUSH discards pending values.
      applyStimulus(TH_A, $urandom);
      applyStimulus(WS_A, 32'd200);
      applyStimulus(CTRL_A, 32'h3);
      stepClock();
      stepClock();
      checkOutput("pre_rst_sclr", 32'(dp_sclr), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      modelReset();
      checkOutput("arst_sclr", 32'(dp_sclr), 32'd1);
      checkOutput("arst_en", 32'(dp_enable), 32'd0);
      checkOutput("arst_ws", 32'(window_size), 32'd64);
      checkOutput("arst_th", th_value, 32'hFFFF_FFFF);
      #2;
      reset = 1'b1;
      stepClock();
      enableFromIdle("post_rst");

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
